// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared defaults, state type and helpers for the life writeback stage
package life_pkg;

    localparam int WORD_SIZE      = 32;
    localparam int LOG_WORD_SIZE  = $clog2(WORD_SIZE);
    localparam int BOARD_SIZE     = 64;
    localparam int LOG_BOARD_SIZE = $clog2(BOARD_SIZE);
    localparam int LOG_MAX_ADDR   = 12;
    localparam int NUM_PE         = 2;
    localparam int MAX_PE         = 64;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_RUN  = 1'b1
    } wb_state_t;

    function automatic int bank_words(input int board_size, input int word_size);
        return (board_size * board_size) / word_size;
    endfunction

    // Callers zero-extend their NUM_PE-bit beat to MAX_PE bits.
    function automatic logic [7:0] popcount(input logic [MAX_PE-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < MAX_PE; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/life_word_packer.sv
// rtl/life_word_packer.sv - packs NUM_PE-cell beats MSB-first into words, flags each completed word
module life_word_packer
    import life_pkg::*;
#(
    parameter int WORD_SIZE = life_pkg::WORD_SIZE,
    parameter int NUM_PE    = life_pkg::NUM_PE
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 clear_in,
    input  logic                 beat_in,
    input  logic [NUM_PE-1:0]    state_in,
    output logic                 word_done_out,
    output logic [WORD_SIZE-1:0] word_out
);

    localparam int BEATS = WORD_SIZE / NUM_PE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last_beat;

    assign w_last_beat   = (r_cnt == CNT_W'(BEATS - 1));
    assign word_done_out = beat_in && w_last_beat;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear_in) begin
            r_cnt <= '0;
        end else if (beat_in) begin
            r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
        end
    end

    // The word seen downstream already includes the beat being accepted now.
    generate
        if (NUM_PE < WORD_SIZE) begin : g_shift
            logic [WORD_SIZE-NUM_PE-1:0] r_shift;

            assign word_out = {r_shift, state_in};

            always_ff @(posedge clk_in) begin
                if (!rst_n_in || clear_in) begin
                    r_shift <= '0;
                end else if (beat_in) begin
                    r_shift <= word_out[WORD_SIZE-NUM_PE-1:0];
                end
            end
        end else begin : g_direct
            assign word_out = state_in;
        end
    endgenerate

endmodule

// File: rtl/life_writeback_pp.sv
// rtl/life_writeback_pp.sv - ping-pong bank writeback with population count and overrun flag
module life_writeback_pp
    import life_pkg::*;
#(
    parameter int WORD_SIZE    = life_pkg::WORD_SIZE,
    parameter int NUM_PE       = life_pkg::NUM_PE,
    parameter int BOARD_SIZE   = life_pkg::BOARD_SIZE,
    parameter int LOG_MAX_ADDR = life_pkg::LOG_MAX_ADDR,
    parameter int POP_W        = LOG_MAX_ADDR + $clog2(WORD_SIZE) + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic                    bank_in,
    input  logic                    valid_in,
    input  logic [NUM_PE-1:0]       state_in,
    output logic                    wr_en_out,
    output logic [LOG_MAX_ADDR-1:0] addr_w_out,
    output logic [WORD_SIZE-1:0]    data_w_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [POP_W-1:0]        population_out,
    output logic                    err_out
);

    localparam int BANK_WORDS = bank_words(BOARD_SIZE, WORD_SIZE);

    wb_state_t               r_state;
    logic [LOG_MAX_ADDR-1:0] r_base;
    logic [LOG_MAX_ADDR-1:0] r_idx;
    logic                    r_wr_en;
    logic [LOG_MAX_ADDR-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_data;
    logic                    r_last;
    logic                    r_done;
    logic [POP_W-1:0]        r_pop;
    logic                    r_err;

    logic                    w_busy;
    logic                    w_beat;
    logic                    w_word_done;
    logic [WORD_SIZE-1:0]    w_word;
    logic [7:0]              w_beat_pop;

    assign w_busy     = (r_state == WB_RUN);
    // A start in the same cycle discards the beat, including one that would finish a word.
    assign w_beat     = valid_in && w_busy && !start_in;
    assign w_beat_pop = popcount(MAX_PE'(state_in));

    life_word_packer #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_PE    (NUM_PE)
    ) u_packer (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .clear_in      (start_in),
        .beat_in       (w_beat),
        .state_in      (state_in),
        .word_done_out (w_word_done),
        .word_out      (w_word)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= WB_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_pop   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= r_last;
            if (start_in) begin
                r_state <= WB_RUN;
                r_base  <= bank_in ? LOG_MAX_ADDR'(BANK_WORDS) : '0;
                r_idx   <= '0;
                r_done  <= 1'b0;
                r_pop   <= '0;
                r_err   <= 1'b0;
            end else begin
                if (valid_in && !w_busy) begin
                    r_err <= 1'b1;
                end
                if (w_beat) begin
                    r_pop <= r_pop + POP_W'(w_beat_pop);
                end
                if (w_word_done) begin
                    r_wr_en <= 1'b1;
                    r_data  <= w_word;
                    r_addr  <= r_base + r_idx;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LOG_MAX_ADDR'(BANK_WORDS - 1)) begin
                        r_state <= WB_IDLE;
                        r_last  <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_en_out      = r_wr_en;
    assign addr_w_out     = r_addr;
    assign data_w_out     = r_data;
    assign busy_out       = w_busy;
    assign done_out       = r_done;
    assign population_out = r_pop;
    assign err_out        = r_err;

endmodule

// File: tb/tb_life_writeback_pp.sv
// tb/tb_life_writeback_pp.sv - directed self-checking bench for life_writeback_pp
module tb_life_writeback_pp;

    localparam int WS = 8;
    localparam int PE = 2;
    localparam int BS = 8;
    localparam int LA = 12;
    localparam int PW = LA + $clog2(WS) + 1;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start_in;
    logic          bank_in;
    logic          valid_in;
    logic [PE-1:0] state_in;
    logic          wr_en_out;
    logic [LA-1:0] addr_w_out;
    logic [WS-1:0] data_w_out;
    logic          busy_out;
    logic          done_out;
    logic [PW-1:0] population_out;
    logic          err_out;

    int n_vec = 0;
    int n_bad = 0;

    life_writeback_pp #(
        .WORD_SIZE    (WS),
        .NUM_PE       (PE),
        .BOARD_SIZE   (BS),
        .LOG_MAX_ADDR (LA)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .bank_in        (bank_in),
        .valid_in       (valid_in),
        .state_in       (state_in),
        .wr_en_out      (wr_en_out),
        .addr_w_out     (addr_w_out),
        .data_w_out     (data_w_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .population_out (population_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_start(input logic bank);
        start_in = 1'b1;
        bank_in  = bank;
        valid_in = 1'b0;
        tick();
        start_in = 1'b0;
    endtask

    task automatic beat(input logic [PE-1:0] s);
        valid_in = 1'b1;
        state_in = s;
        tick();
        valid_in = 1'b0;
    endtask

    logic [PE-1:0] pat [4];

    initial begin
        pat[0] = 2'b11; pat[1] = 2'b00; pat[2] = 2'b01; pat[3] = 2'b10;

        // Reset dominates start and valid
        rst_n_in = 1'b0; start_in = 1'b1; bank_in = 1'b1; valid_in = 1'b1; state_in = 2'b11;
        repeat (3) begin
            tick();
            chk("rst_wr_en", wr_en_out, 0);
        end
        chk("rst_addr", addr_w_out, 0);
        chk("rst_data", data_w_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_pop", population_out, 0);
        chk("rst_err", err_out, 0);
        rst_n_in = 1'b1; start_in = 1'b0; valid_in = 1'b0;
        tick();

        // Bank 0, continuous 2'b10 beats
        do_start(1'b0);
        chk("b0_busy_start", busy_out, 1);
        chk("b0_pop_start", population_out, 0);
        for (int i = 0; i < 32; i++) begin
            valid_in = 1'b1; state_in = 2'b10;
            tick();
            chk("b0_wr_en", wr_en_out, (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) begin
                chk("b0_addr", addr_w_out, i / 4);
                chk("b0_data", data_w_out, 8'hAA);
            end
            chk("b0_busy", busy_out, (i == 31) ? 0 : 1);
        end
        valid_in = 1'b0;
        tick();
        chk("b0_done", done_out, 1);
        chk("b0_wr_after", wr_en_out, 0);
        tick();
        chk("b0_done_drop", done_out, 0);
        chk("b0_pop", population_out, 32);

        // Bank 1, valid toggling
        do_start(1'b1);
        for (int c = 0; c < 64; c++) begin
            valid_in = (c % 2 == 0);
            state_in = pat[(c / 2) % 4];
            tick();
            chk("b1_wr_en", wr_en_out, (c % 8 == 6) ? 1 : 0);
            if (c % 8 == 6) begin
                chk("b1_addr", addr_w_out, 8 + c / 8);
                chk("b1_data", data_w_out, 8'hC6);
            end
            chk("b1_done", done_out, (c == 63) ? 1 : 0);
        end
        valid_in = 1'b0;
        chk("b1_pop", population_out, 32);
        chk("b1_busy", busy_out, 0);

        // Overrun while idle
        valid_in = 1'b1; state_in = 2'b11;
        tick();
        chk("ovr_err", err_out, 1);
        chk("ovr_wr_en", wr_en_out, 0);
        tick();
        chk("ovr_err_hold", err_out, 1);
        chk("ovr_pop", population_out, 32);
        valid_in = 1'b0;
        tick();
        chk("ovr_err_sticky", err_out, 1);
        chk("ovr_wr_en2", wr_en_out, 0);

        // Abort mid-word
        do_start(1'b0);
        chk("ab_err_clr", err_out, 0);
        for (int i = 0; i < 6; i++) begin
            beat(2'b11);
            chk("ab_wr_en", wr_en_out, (i == 3) ? 1 : 0);
            if (i == 3) begin
                chk("ab_addr", addr_w_out, 0);
                chk("ab_data", data_w_out, 8'hFF);
            end
        end
        do_start(1'b1);
        chk("ab_wr_at_abort", wr_en_out, 0);
        chk("ab_pop_clr", population_out, 0);
        chk("ab_busy", busy_out, 1);
        for (int i = 0; i < 4; i++) begin
            beat(2'b11);
            chk("ab2_wr_en", wr_en_out, (i == 3) ? 1 : 0);
        end
        chk("ab2_addr", addr_w_out, 8);
        chk("ab2_data", data_w_out, 8'hFF);
        chk("ab2_pop", population_out, 8);

        // Start coincident with a completing beat
        for (int i = 0; i < 3; i++) beat(2'b01);
        start_in = 1'b1; bank_in = 1'b0; valid_in = 1'b1; state_in = 2'b01;
        tick();
        start_in = 1'b0; valid_in = 1'b0;
        chk("co_wr_en", wr_en_out, 0);
        chk("co_pop", population_out, 0);
        chk("co_busy", busy_out, 1);
        for (int i = 0; i < 4; i++) begin
            beat(2'b01);
            chk("co2_wr_en", wr_en_out, (i == 3) ? 1 : 0);
        end
        chk("co2_addr", addr_w_out, 0);
        chk("co2_data", data_w_out, 8'h55);
        chk("co2_pop", population_out, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/life_writeback_pp.md
Name: life_writeback_pp

Overview:
- Parametrised successor to the single-bank writeback stage of the life update pipeline.
- Accepts NUM_PE next-state cells per beat from the rule stage and packs them MSB-first into WORD_SIZE words.
- Writes each word into one of two ping-pong board banks, selected at start, so display can read the old generation while the new one is written.
- Adds valid/stall handling, a generation-done pulse, a live-cell population count and overrun error detection.

Parameters:
- WORD_SIZE, 32, bits per memory word; WORD_SIZE % NUM_PE == 0.
- NUM_PE, 2, cells delivered per accepted beat.
- BOARD_SIZE, 64, cells per board side; (BOARD_SIZE*BOARD_SIZE) % WORD_SIZE == 0.
- LOG_MAX_ADDR, 12, write address width; must hold 2*BANK_WORDS-1.
- BANK_WORDS, BOARD_SIZE*BOARD_SIZE/WORD_SIZE, derived; words per bank, not overridden.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: synchronous, active-low reset.
- start_in, input, 1: begin a new generation; one-cycle pulse.
- bank_in, input, 1: destination bank, sampled only when start_in=1.
- valid_in, input, 1: state_in holds a valid beat (inverse of the rule-stage stall).
- state_in, input, NUM_PE: next-state cells; bit NUM_PE-1 is the lowest x.
- wr_en_out, output, 1: write strobe, one cycle per completed word.
- addr_w_out, output, LOG_MAX_ADDR: bank base + word index.
- data_w_out, output, WORD_SIZE: packed word; MSB is the lowest x.
- busy_out, output, 1: generation in progress.
- done_out, output, 1: one-cycle pulse after the last word write.
- population_out, output, LOG_MAX_ADDR+LOG2(WORD_SIZE)+1: live cells written this generation.
- err_out, output, 1: sticky overrun flag.

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - All outputs go to 0.
  - The beat counter, word index and shift register are cleared.
  - Reset overrides start_in and valid_in.
- Start (start_in=1):
  - Next cycle: busy_out=1, wr_en_out=0, done_out=0, err_out=0, population_out=0.
  - Beat count=0, word index=0, shift register cleared.
  - Bank base is latched: bank_in=0 gives base 0; bank_in=1 gives base BANK_WORDS.
  - Start while busy aborts the generation: the partial word is discarded and no write is issued, not even one that completes in the same cycle.
- States: IDLE -> RUN on start_in. RUN -> IDLE on the cycle the last word is written.
- Accepted beat: valid_in=1 and busy_out=1.
  - shift <= {shift[WORD_SIZE-NUM_PE-1:0], state_in}.
  - Beat count increments modulo WORD_SIZE/NUM_PE.
  - population_out increases by popcount(state_in) in the same edge.
- Word completion: the beat that brings the count to WORD_SIZE/NUM_PE produces, on the next cycle:
  - wr_en_out=1 for exactly one cycle;
  - data_w_out = the completed word, held until the next completed word;
  - addr_w_out = base + word index; the word index then increments.
- Latency: 1 cycle from the completing beat to wr_en_out.
- Back-to-back completions are supported (NUM_PE == WORD_SIZE gives a write every beat).
- Stall: valid_in=0 freezes all counters and the shift register. wr_en_out still drops after one cycle.
- Generation end: the cycle the word with index BANK_WORDS-1 is written, busy_out goes to 0. done_out=1 on the following cycle only.
- population_out holds its final value until the next start or reset.
- Overrun: valid_in=1 while busy_out=0 sets err_out. The beat is ignored, with no write and no count change. err_out clears only on start or reset.
- start_in and valid_in in the same cycle: start wins and the beat is dropped.
- Arithmetic: address addition is unsigned with no wrap; parameter constraints guarantee range. The population counter never saturates, because its width covers BOARD_SIZE^2.

Decomposition:
- life_pkg:
  - WORD_SIZE, LOG_WORD_SIZE, BOARD_SIZE, LOG_BOARD_SIZE, LOG_MAX_ADDR, NUM_PE defaults;
  - the BANK_WORDS derivation;
  - enum wb_state_t {WB_IDLE, WB_RUN}.
- Sub-module life_word_packer (shift register plus beat counter, emits a word_done strobe). The top level owns addressing, banking, population and the flags.
- popcount of NUM_PE bits is a package function.

Test Plan (WORD_SIZE=8, NUM_PE=2, BOARD_SIZE=8, so BANK_WORDS=8 and 4 beats per word):
- Reset: hold rst_n_in=0 with start_in=1 and valid_in=1 -> all outputs 0, no wr_en_out.
- Bank 0, 32 continuous beats of 2'b10 after start -> 8 writes of 8'hAA to addr 0..7, each one cycle after every 4th beat; busy_out falls with the addr-7 write; done_out pulses the next cycle; population_out=32.
- Bank 1, valid_in toggling 1/0 for 64 cycles, beats 11,00,01,10 repeated -> 8 writes of 8'hC6 to addr 8..15, spaced 8 cycles apart; population_out=32.
- Abort: start bank 0, 6 beats of 2'b11, then start bank 1 -> exactly one write (8'hFF at addr 0) before the abort, none at the abort, population_out reset to 0; the next 4 beats write to addr 8.
- Overrun: after done_out, drive valid_in=1 with 2'b11 -> err_out=1 and stays 1, no writes, population unchanged; the next start clears err_out.
- Start coincident with a completing beat -> no write is issued and the beat is not counted.
